alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-cycle control unit that drives the ALU/register-file datapath's control inputs: ALUControl, ALUSrc, RA1, RA2, WA, immediate and write_enable.
- Fetches 16-bit instructions from a synchronous instruction ROM and decodes them.
- Sequences each instruction through FETCH, DECODE and EXECUTE.
- Latches the datapath's zero output into a flag that conditional branches use.

Parameters:
- PC_W, 8, instruction address width; PC wraps modulo 2^PC_W.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- CLK  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  when low, FSM, PC, IR and flag hold and write_enable is forced 0.
- imem_addr  output  PC_W  instruction ROM address; ROM returns data one cycle later.
- imem_rdata  input  16  instruction word from ROM.
- zero  input  1  datapath ALU zero flag (combinational from current controls).
- ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 OR.
- ALUSrc  output  1  1 selects immediate as ALU operand B.
- RA1, RA2, WA  output  4 each  register-file read/write addresses.
- immediate  output  8  immediate operand.
- write_enable  output  1  register-file write strobe.
- halted  output  1  high once HALT has executed.
- pc  output  PC_W  current PC, for debug.

Behaviour:
- Instruction format: op=[15:12], rd=[11:8], rs1=[7:4], rs2=[3:0], imm/target=[7:0].
- Opcode 0x0-0x3 (ADD/SUB/AND/OR reg):
  - ALUControl=op[1:0], ALUSrc=0.
  - RA1=rs1, RA2=rs2, WA=rd.
  - Writes the register file; updates the zero flag.
- Opcode 0x4-0x7 (ADDI/SUBI/ANDI/ORI):
  - ALUControl=op[1:0], ALUSrc=1, immediate=imm.
  - RA1=rd, WA=rd, RA2=0.
  - Writes the register file; updates the zero flag.
- Opcode 0x8 BZ: if flag=1 then PC<=target, else PC+1. No register write, flag unchanged.
- Opcode 0x9 BNZ: same as BZ with the condition inverted.
- Opcode 0xA JMP: PC<=target unconditionally.
- Opcode 0xF HALT: go to HALTED, PC unchanged.
- Opcodes 0xB-0xE: NOP. PC+1, no write, flag unchanged.
- States:
  - FETCH: imem_addr=PC.
  - DECODE: IR<=imem_rdata.
  - EXECUTE: controls valid, write_enable=1 for ALU ops, PC and flag updated on the exiting edge.
  - Next state: back to FETCH, or to HALTED for HALT.
  - Each instruction takes exactly 3 cycles while enable=1.
- imem_addr=PC in all states.
- RA1/RA2/WA/ALUControl/ALUSrc/immediate are combinational decode of IR, stable in DECODE and EXECUTE. write_enable is high only in EXECUTE, with enable=1 and reset=0.
- Flag latch: at the EXECUTE exit edge of an ALU op, flag<=zero.
- HALTED is absorbing until reset: write_enable=0, halted=1.
- Reset values: state=FETCH, PC=RESET_PC, IR=0, flag=0, halted=0, write_enable=0, and all control outputs 0 (IR=0 decodes to zeros).
- Reset beats enable. Reset asserted in EXECUTE suppresses that cycle's write, since write_enable is gated by reset combinationally.
- enable=0 in EXECUTE: no write, state held, and the instruction completes once enable returns. No double write.
- PC wrap: PC=2^PC_W-1 with PC+1 gives 0. Branch targets wider than PC_W are truncated.
- Branch and JMP never assert write_enable.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode enum (OP_ADD..OP_HALT);
  - state enum (S_FETCH, S_DECODE, S_EXECUTE, S_HALTED);
  - ALUControl localparams (ALU_ADD=2'b00 etc.);
  - instruction field bit positions.
- Sub-module alu_seq_decode: purely combinational IR → control fields plus is_alu/is_branch/is_halt.
- Top level holds the FSM, PC, IR and flag.

Test Plan:
- Reset, then ROM[0]=0x4105 (ADDI r1,5) with zero=0 → cycle 3: ALUSrc=1, ALUControl=00, RA1=WA=1, immediate=0x05, write_enable=1 for exactly 1 cycle; pc=1 afterwards.
- ROM[1]=0x1212 (SUB r2,r1,r2) with zero=1 during EXECUTE → RA1=1, RA2=2, WA=2, ALUControl=01; then ROM[2]=0x8010 (BZ 0x10) → pc=0x10, write_enable never high.
- BNZ 0x20 with flag=1 → pc=prev+1; JMP 0x05 → pc=5; opcode 0xC → pc+1, no write.
- HALT at address 7 → halted=1 from next cycle, state stays HALTED for 20 cycles, pc=7, write_enable=0; reset → pc=0, halted=0.
- enable=0 held 4 cycles during EXECUTE of ADD → write_enable=0 throughout; on release, one write pulse, pc advances once.
- PC=0xFF executing NOP → pc=0x00; reset asserted during an EXECUTE with an ALU op → write_enable=0 that cycle, next state FETCH, pc=RESET_PC.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU/register-file control sequencer.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_ADDI = 4'h4,
    OP_SUBI = 4'h5,
    OP_ANDI = 4'h6,
    OP_ORI  = 4'h7,
    OP_BZ   = 4'h8,
    OP_BNZ  = 4'h9,
    OP_JMP  = 4'hA,
    OP_NOP  = 4'hB,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DECODE  = 2'd1,
    S_EXECUTE = 2'd2,
    S_HALTED  = 2'd3
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // Instruction field bit positions
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // Map the low opcode bits of an ALU instruction onto the datapath ALU select.
  function automatic logic [1:0] alu_sel(input logic [1:0] op_lo);
    logic [1:0] sel;
    case (op_lo)
      2'b00:   sel = ALU_ADD;
      2'b01:   sel = ALU_SUB;
      2'b10:   sel = ALU_AND;
      default: sel = ALU_OR;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction-ROM and datapath-control bundle between the sequencer and the datapath.
interface alu_sequencer_if #(
  parameter int PC_W = 8
);
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_rdata;
  logic            zero;
  logic [1:0]      ALUControl;
  logic            ALUSrc;
  logic [3:0]      RA1;
  logic [3:0]      RA2;
  logic [3:0]      WA;
  logic [7:0]      immediate;
  logic            write_enable;

  modport master (
    output imem_addr, ALUControl, ALUSrc, RA1, RA2, WA, immediate, write_enable,
    input  imem_rdata, zero
  );

  modport slave (
    input  imem_addr, ALUControl, ALUSrc, RA1, RA2, WA, immediate, write_enable,
    output imem_rdata, zero
  );
endinterface

// File: rtl/alu_seq_decode.sv
// Combinational instruction decode: IR to datapath controls and instruction class.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [15:0] ir_i,
  output logic [1:0]  alu_ctrl_o,
  output logic        alu_src_o,
  output logic [3:0]  ra1_o,
  output logic [3:0]  ra2_o,
  output logic [3:0]  wa_o,
  output logic [7:0]  imm_o,
  output logic [7:0]  target_o,
  output logic        is_alu_o,
  output logic        is_branch_o,
  output logic        br_uncond_o,
  output logic        br_on_zero_o,
  output logic        is_halt_o
);

  opcode_e    op;
  logic [3:0] rd;
  logic [3:0] rs1;
  logic [3:0] rs2;

  assign op       = opcode_e'(ir_i[OP_MSB:OP_LSB]);
  assign rd       = ir_i[RD_MSB:RD_LSB];
  assign rs1      = ir_i[RS1_MSB:RS1_LSB];
  assign rs2      = ir_i[RS2_MSB:RS2_LSB];
  assign target_o = ir_i[IMM_MSB:IMM_LSB];

  // Non-ALU instructions drive all datapath controls to zero.
  always_comb begin
    alu_ctrl_o   = '0;
    alu_src_o    = 1'b0;
    ra1_o        = '0;
    ra2_o        = '0;
    wa_o         = '0;
    imm_o        = '0;
    is_alu_o     = 1'b0;
    is_branch_o  = 1'b0;
    br_uncond_o  = 1'b0;
    br_on_zero_o = 1'b0;
    is_halt_o    = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        alu_ctrl_o = alu_sel(ir_i[OP_LSB+1:OP_LSB]);
        ra1_o      = rs1;
        ra2_o      = rs2;
        wa_o       = rd;
        is_alu_o   = 1'b1;
      end
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: begin
        alu_ctrl_o = alu_sel(ir_i[OP_LSB+1:OP_LSB]);
        alu_src_o  = 1'b1;
        imm_o      = ir_i[IMM_MSB:IMM_LSB];
        ra1_o      = rd;
        wa_o       = rd;
        is_alu_o   = 1'b1;
      end
      OP_BZ: begin
        is_branch_o  = 1'b1;
        br_on_zero_o = 1'b1;
      end
      OP_BNZ: begin
        is_branch_o = 1'b1;
      end
      OP_JMP: begin
        is_branch_o = 1'b1;
        br_uncond_o = 1'b1;
      end
      OP_HALT: begin
        is_halt_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the ALU/register-file datapath.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_FETCH   | imem_addr=PC presented, ROM word arrives next cycle
// S_DECODE  | ROM word captured into IR at the end of this cycle
// S_EXECUTE | controls valid, write strobe for ALU ops, PC/flag update
// S_HALTED  | absorbing after HALT until reset, no writes
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   enable,
  alu_sequencer_if.master        bus,
  output logic                   halted,
  output logic [PC_W-1:0]        pc
);

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [15:0]     ir_q;
  logic            flag_q;
  logic            halted_q;

  logic [7:0] target;
  logic       is_alu;
  logic       is_branch;
  logic       br_uncond;
  logic       br_on_zero;
  logic       is_halt;

  alu_seq_decode u_decode (
    .ir_i         (ir_q),
    .alu_ctrl_o   (bus.ALUControl),
    .alu_src_o    (bus.ALUSrc),
    .ra1_o        (bus.RA1),
    .ra2_o        (bus.RA2),
    .wa_o         (bus.WA),
    .imm_o        (bus.immediate),
    .target_o     (target),
    .is_alu_o     (is_alu),
    .is_branch_o  (is_branch),
    .br_uncond_o  (br_uncond),
    .br_on_zero_o (br_on_zero),
    .is_halt_o    (is_halt)
  );

  // Reset gates the strobe combinationally so an EXECUTE hit by reset never writes.
  assign bus.write_enable = (state_q == S_EXECUTE) && is_alu && enable && !reset;
  assign bus.imem_addr    = pc_q;
  assign pc               = pc_q;
  assign halted           = halted_q;

  // Next PC at EXECUTE exit: BZ takes when flag=1, BNZ when flag=0, JMP always.
  always_comb begin
    pc_d = pc_q + PC_W'(1);
    if (is_branch && (br_uncond || (flag_q == br_on_zero))) begin
      pc_d = PC_W'(target);
    end
  end

  // Sequencer FSM with PC, IR, zero flag and halted registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      flag_q   <= 1'b0;
      halted_q <= 1'b0;
    end else if (enable) begin
      case (state_q)
        S_FETCH: begin
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          ir_q    <= bus.imem_rdata;
          state_q <= S_EXECUTE;
        end
        S_EXECUTE: begin
          if (is_halt) begin
            state_q  <= S_HALTED;
            halted_q <= 1'b1;
          end else begin
            state_q <= S_FETCH;
            pc_q    <= pc_d;
            if (is_alu) begin
              flag_q <= bus.zero;
            end
          end
        end
        default: begin
          state_q <= S_HALTED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a write-strobe scoreboard.
module tb_alu_sequencer;

  logic       CLK;
  logic       reset;
  logic       enable;
  logic       halted;
  logic [7:0] pc;

  logic [15:0] rom [256];
  logic [22:0] exp_q[$];

  int n_vec = 0;
  int n_bad = 0;

  alu_sequencer_if #(.PC_W(8)) bus ();

  alu_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .CLK    (CLK),
    .reset  (reset),
    .enable (enable),
    .bus    (bus),
    .halted (halted),
    .pc     (pc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous ROM: data one cycle after the address
  always @(posedge CLK) bus.imem_rdata <= rom[bus.imem_addr];

  function automatic logic [22:0] ctl_now();
    return {bus.ALUControl, bus.ALUSrc, bus.RA1, bus.RA2, bus.WA, bus.immediate};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next expected control set
  initial begin
    forever begin
      @(negedge CLK);
      if (bus.write_enable === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_write: got ctl %0h at pc %0h expected no write", ctl_now(), pc);
        end else begin
          check("write_ctl", {9'd0, ctl_now()}, {9'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  // Called at a FETCH-cycle negedge; runs one instruction to the next FETCH
  task automatic run_instr(input logic zero_v, input logic [7:0] exp_pc, input bit exp_wr,
                           input logic [22:0] exp_ctl, input string name);
    bus.zero = zero_v;
    if (exp_wr) exp_q.push_back(exp_ctl);
    tick();
    tick();
    tick();
    check({name, "_pc"}, {24'd0, pc}, {24'd0, exp_pc});
    check({name, "_we_after"}, {31'd0, bus.write_enable}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'hB000;
    rom[8'h00] = 16'h4105;
    rom[8'h01] = 16'h1212;
    rom[8'h02] = 16'h8010;
    rom[8'h10] = 16'h9020;
    rom[8'h11] = 16'hA005;
    rom[8'h05] = 16'hC000;
    rom[8'h06] = 16'h0345;
    rom[8'h07] = 16'hF000;

    reset    = 1'b1;
    enable   = 1'b1;
    bus.zero = 1'b0;
    repeat (2) tick();
    check("rst_pc", {24'd0, pc}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_we", {31'd0, bus.write_enable}, 32'd0);
    check("rst_ctl", {9'd0, ctl_now()}, 32'd0);
    reset = 1'b0;

    run_instr(1'b0, 8'h01, 1'b1, {2'b00, 1'b1, 4'd1, 4'd0, 4'd1, 8'h05}, "addi");
    run_instr(1'b1, 8'h02, 1'b1, {2'b01, 1'b0, 4'd1, 4'd2, 4'd2, 8'h00}, "sub");
    run_instr(1'b0, 8'h10, 1'b0, 23'd0, "bz_taken");
    run_instr(1'b0, 8'h11, 1'b0, 23'd0, "bnz_not_taken");
    run_instr(1'b0, 8'h05, 1'b0, 23'd0, "jmp");
    run_instr(1'b0, 8'h06, 1'b0, 23'd0, "nop");

    // ADD r3,r4,r5 with enable dropped for the EXECUTE cycle
    bus.zero = 1'b0;
    exp_q.push_back({2'b00, 1'b0, 4'd4, 4'd5, 4'd3, 8'h00});
    tick();
    @(posedge CLK);
    #1 enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_we", {31'd0, bus.write_enable}, 32'd0);
      check("stall_pc", {24'd0, pc}, 32'h06);
    end
    @(posedge CLK);
    #1 enable = 1'b1;
    tick();
    tick();
    check("stall_release_pc", {24'd0, pc}, 32'h07);

    // HALT at 7
    tick();
    tick();
    check("halt_exec_halted", {31'd0, halted}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      bus.zero = ~bus.zero;
      check("halted", {31'd0, halted}, 32'd1);
      check("halted_pc", {24'd0, pc}, 32'h07);
      check("halted_we", {31'd0, bus.write_enable}, 32'd0);
    end

    reset = 1'b1;
    tick();
    check("halt_rst_pc", {24'd0, pc}, 32'd0);
    check("halt_rst_halted", {31'd0, halted}, 32'd0);

    // PC wrap and reset in EXECUTE
    rom[8'h00] = 16'hA0FF;
    rom[8'hFF] = 16'hC000;
    bus.zero   = 1'b0;
    reset      = 1'b0;
    run_instr(1'b0, 8'hFF, 1'b0, 23'd0, "jmp_ff");
    rom[8'h00] = 16'h2678;
    run_instr(1'b0, 8'h00, 1'b0, 23'd0, "nop_wrap");
    tick();
    @(posedge CLK);
    #1 reset = 1'b1;
    #1;
    check("rst_exec_ra1", {28'd0, bus.RA1}, 32'd7);
    check("rst_exec_we", {31'd0, bus.write_enable}, 32'd0);
    tick();
    tick();
    check("rst_exec_pc", {24'd0, pc}, 32'd0);
    check("rst_exec_ctl", {9'd0, ctl_now()}, 32'd0);
    reset = 1'b0;
    run_instr(1'b0, 8'h01, 1'b1, {2'b10, 1'b0, 4'd7, 4'd8, 4'd6, 8'h00}, "and_after_rst");

    tick();
    check("pending_writes", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
